// File: rtl/key_debounce.sv
// key_debounce: synchronised, hold-time filtered front end for active-low push buttons.
// Each key reports a clean level, one-cycle press/release pulses and a press-toggled state.
module key_debounce #(
    parameter int unsigned KEY_NUM = 4,
    parameter int unsigned CNT_MAX = 1_000_000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [KEY_NUM-1:0] key,
    output logic [KEY_NUM-1:0] key_level,
    output logic [KEY_NUM-1:0] key_press,
    output logic [KEY_NUM-1:0] key_release,
    output logic [KEY_NUM-1:0] key_toggle
);

    localparam int unsigned   CntW    = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(CNT_MAX - 1);

    typedef enum logic [1:0] {
        StIdle,
        StPressWait,
        StPressed,
        StReleaseWait
    } state_e;

    logic [KEY_NUM-1:0] s1_q;
    logic [KEY_NUM-1:0] s2_q;

    // Two-flop synchroniser; resets to released so reset exit never looks like a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= '1;
            s2_q <= '1;
        end else begin
            s1_q <= key;
            s2_q <= s1_q;
        end
    end

    for (genvar i = 0; i < KEY_NUM; i++) begin : g_key
        state_e          state_q, state_d;
        logic [CntW-1:0] cnt_q, cnt_d;
        logic            level_q, level_d;
        logic            press_q, press_d;
        logic            release_q, release_d;
        logic            toggle_q, toggle_d;
        logic            low;

        // s2 low means the key is currently held.
        assign low = ~s2_q[i];

        // Next-state logic: qualify each level change over CNT_MAX consecutive samples.
        always_comb begin
            state_d   = state_q;
            cnt_d     = cnt_q;
            level_d   = level_q;
            press_d   = 1'b0;
            release_d = 1'b0;
            toggle_d  = toggle_q;
            unique case (state_q)
                StIdle: begin
                    cnt_d = '0;
                    if (low) state_d = StPressWait;
                end
                StPressWait: begin
                    if (!low) begin
                        state_d = StIdle;
                        cnt_d   = '0;
                    end else if (cnt_q == CntLast) begin
                        state_d  = StPressed;
                        cnt_d    = '0;
                        level_d  = 1'b1;
                        press_d  = 1'b1;
                        toggle_d = ~toggle_q;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
                StPressed: begin
                    cnt_d = '0;
                    if (!low) state_d = StReleaseWait;
                end
                StReleaseWait: begin
                    if (low) begin
                        state_d = StPressed;
                        cnt_d   = '0;
                    end else if (cnt_q == CntLast) begin
                        state_d   = StIdle;
                        cnt_d     = '0;
                        level_d   = 1'b0;
                        release_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
                default: begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            endcase
        end

        // State, counter and registered outputs; reset clears everything asynchronously.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q   <= StIdle;
                cnt_q     <= '0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                toggle_q  <= 1'b0;
            end else begin
                state_q   <= state_d;
                cnt_q     <= cnt_d;
                level_q   <= level_d;
                press_q   <= press_d;
                release_q <= release_d;
                toggle_q  <= toggle_d;
            end
        end

        assign key_level[i]   = level_q;
        assign key_press[i]   = press_q;
        assign key_release[i] = release_q;
        assign key_toggle[i]  = toggle_q;
    end

endmodule

// File: doc/key_debounce.md
# key_debounce

Debounced push-button front end for the board's active-low keys. Its outputs feed the LED driver and user logic, so it is the input-side counterpart of the LED output path. Each key is synchronised, filtered by a per-key hold-time counter, and reported three ways: a clean level, one-cycle press/release pulses, and a per-key toggle state that can drive an LED directly.

## Interface
- KEY_NUM, 4: number of independent keys.
- CNT_MAX, 1_000_000: stable-time qualification in clk cycles (20 ms at 50 MHz); legal range ≥ 2. Benches use 10.
- clk  input  1  system clock, 50 MHz, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- key  input  KEY_NUM  raw key pins, active-low (0 = pressed), asynchronous to clk.
- key_level  output  KEY_NUM  debounced level, 1 = pressed.
- key_press  output  KEY_NUM  one-cycle pulse on a qualified press.
- key_release  output  KEY_NUM  one-cycle pulse on a qualified release.
- key_toggle  output  KEY_NUM  flips on every qualified press; intended to drive LEDs.

## Operation
- Per key: 2-flop synchroniser (s1, s2). Both flops reset to 1 (released) so that reset release cannot produce a false press.
- Per key FSM on s2, with a hold counter `cnt` of width $clog2(CNT_MAX):
  - IDLE: key released. If s2 = 0, go to PRESS_WAIT with cnt = 0.
  - PRESS_WAIT: if s2 = 1, go to IDLE (bounce rejected, cnt cleared). Otherwise cnt++. On an edge where cnt == CNT_MAX-1 and s2 = 0, go to PRESSED, set key_level = 1, pulse key_press, and invert key_toggle.
  - PRESSED: if s2 = 1, go to RELEASE_WAIT with cnt = 0.
  - RELEASE_WAIT: if s2 = 0, return to PRESSED (no pulse). Otherwise cnt++. On an edge where cnt == CNT_MAX-1 and s2 = 1, go to IDLE, set key_level = 0, and pulse key_release.
- Keys are fully independent. Simultaneous events on several keys each produce their own pulses in the same cycle.
- key_press and key_release are registered. They are high for exactly one cycle and never high together on the same key.
- The counter never wraps. It is cleared on every state entry and is used only in the two WAIT states.
- A key held indefinitely produces exactly one key_press and no repeat.

## Timing
- Reset values: key_level = 0, key_press = 0, key_release = 0, key_toggle = 0, all FSMs in IDLE, cnt = 0, s1 = s2 = 1.
- Reset asserted mid-operation, in any state: all outputs return to their reset values immediately (asynchronous). No pulse is emitted on reset or on reset release.
- Press latency: edge E0 is the first edge that samples key = 0. s2 = 0 after E1. PRESS_WAIT with cnt = 0 after E2. cnt = CNT_MAX-1 after E(CNT_MAX+1). key_press and key_level go high after E(CNT_MAX+2).
  - With CNT_MAX = 10, that is 12 edges.
- Release latency is symmetric: CNT_MAX+2 edges from the first edge sampling key = 1 to key_release.
- Rejection window:
  - A low glitch lasting ≤ CNT_MAX cycles, measured at s2, is rejected.
  - A glitch lasting ≥ CNT_MAX+1 cycles is accepted.
  - Any opposite-level sample restarts qualification from cnt = 0.
- key_press lasts exactly 1 cycle. key_toggle changes on the same edge that key_press rises.

## Test plan
All scenarios use CNT_MAX = 10 and a 20 ns clock.
- Clean press on key[0] held for 40 cycles
  -> key_press[0] is high for 1 cycle, 12 edges after the first low sample.
  -> key_level[0] = 1 from the same edge.
  -> key_toggle[0] goes 0 → 1.
  -> Other bits of all outputs stay 0.
- Bounce on key[1]: low 5 cycles, high 3, low 7, high 3, then low held
  -> no pulse during the bounces.
  -> exactly one key_press[1], 12 edges after the start of the final low.
- Release of key[0] after a qualified press, with release bounce of high 4, low 2, then high held
  -> key_level[0] stays 1 through the bounce.
  -> a single key_release[0] 12 edges after the final high.
  -> no second key_press.
- key[2] and key[3] pressed on the same edge
  -> key_press[2] and key_press[3] pulse in the same cycle.
  -> both toggles flip.
  -> a second full press/release of key[2] returns key_toggle[2] to 0.
- rst_n pulsed low while key[0] is in PRESS_WAIT (cnt = 6), with key held low
  -> all outputs are 0 immediately, and no pulse occurs during reset.
  -> after release, key_press fires 12 edges after the first post-reset low sample.
- Key held low through reset release, then kept low for 100 cycles
  -> exactly one key_press (no repeat).
  -> key_level stays 1 until release.
